// File: rtl/mem_arbiter_fsm_if.sv
// Cache/RAM handshake bundle seen by the memory arbiter.
// The master modport is the arbiter's view; slave is the caches' and RAM's view.
interface mem_arbiter_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              merr;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );
endinterface

// File: rtl/mem_arbiter_fsm.sv
// Icache/dcache arbiter onto a single-port RAM: dcache priority with short bursts,
// starvation counter for icache forward progress, word completion via the wait lines.
module mem_arbiter_fsm #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 2,
    parameter int STARVE_MAX = 4
) (
    input logic               CLK,
    input logic               RST,
    mem_arbiter_fsm_if.master bus
);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [1:0]    RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [BW-1:0] burstCnt;
    logic [BW-1:0] nextBurst;
    logic [SW-1:0] starveCnt;
    logic [SW-1:0] nextStarve;
    logic          iReq;
    logic          dReq;
    logic          xferEnd;

    assign iReq    = bus.iREN;
    assign dReq    = bus.dREN | bus.dWEN;
    assign xferEnd = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            burstCnt  <= '0;
            starveCnt <= '0;
        end else begin
            state     <= nextState;
            burstCnt  <= nextBurst;
            starveCnt <= nextStarve;
        end
    end

    // Arbitration, burst continuation and withdrawal handling.
    always_comb begin
        nextState  = state;
        nextBurst  = burstCnt;
        nextStarve = starveCnt;
        case (state)
            IDLE: begin
                if (dReq && (!iReq || (starveCnt < STARVE_TOP))) begin
                    nextState = GNT_D;
                    nextBurst = '0;
                    if (iReq && (starveCnt != STARVE_TOP)) begin
                        nextStarve = starveCnt + SW'(1);
                    end else begin
                        nextStarve = starveCnt;
                    end
                end else if (iReq) begin
                    nextState  = GNT_I;
                    nextStarve = '0;
                end else begin
                    nextState = IDLE;
                end
            end
            GNT_I: begin
                if (!iReq || xferEnd) begin
                    nextState = IDLE;
                end else begin
                    nextState = GNT_I;
                end
            end
            GNT_D: begin
                // A completed word keeps the grant only while the burst has room;
                // a following cycle without a request releases it through withdrawal.
                if (!dReq) begin
                    nextState = IDLE;
                    nextBurst = '0;
                end else if (xferEnd) begin
                    if (burstCnt < BURST_LAST) begin
                        nextState = GNT_D;
                        nextBurst = burstCnt + BW'(1);
                    end else begin
                        nextState = IDLE;
                        nextBurst = '0;
                    end
                end else begin
                    nextState = GNT_D;
                end
            end
            default: begin
                nextState = IDLE;
                nextBurst = '0;
            end
        endcase
    end

    // RAM drive, completion and error signalling from the current grant.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {DATA_W{1'b0}};
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.merr     = 1'b0;
        case (state)
            GNT_I: begin
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = (bus.ramstate != RAM_ACCESS);
                bus.merr    = (bus.ramstate == RAM_ERROR);
            end
            GNT_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = (bus.ramstate != RAM_ACCESS);
                bus.merr     = (bus.ramstate == RAM_ERROR);
            end
            default: begin
                bus.merr = 1'b0;
            end
        endcase
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed bench for mem_arbiter_fsm: a grant-ownership model checked every cycle
// on two instances (BURST_LEN 2 and 1), plus hand-computed literal expectations.
module tb_mem_arbiter_fsm;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_arbiter_fsm_if bus0 ();
    mem_arbiter_fsm_if bus1 ();

    mem_arbiter_fsm #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(2), .STARVE_MAX(4))
        dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    mem_arbiter_fsm #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(1), .STARVE_MAX(4))
        dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM (0 none, 1 icache, 2 dcache), words served in this
    // dcache grant, and consecutive dcache grants won while the icache was asking.
    typedef struct {
        int owner;
        int words;
        int streak;
    } mstate_t;

    mstate_t m0, m1;
    logic modelValid = 1'b0;

    function automatic mstate_t nextModel(input mstate_t s, input int lim, input int starveMax,
                                          input logic rst, input logic iReq, input logic dR,
                                          input logic dW, input logic [1:0] rs);
        mstate_t n;
        logic dReq;
        logic fin;
        n = s;
        dReq = dR | dW;
        fin = (rs == 2'd2) || (rs == 2'd3);
        if (rst) begin
            n.owner = 0; n.words = 0; n.streak = 0;
        end else if (s.owner == 0) begin
            if (dReq && (!iReq || s.streak < starveMax)) begin
                n.owner = 2;
                n.words = 0;
                if (iReq) n.streak = (s.streak + 1 > starveMax) ? starveMax : s.streak + 1;
            end else if (iReq) begin
                n.owner = 1;
                n.streak = 0;
            end
        end else if (s.owner == 1) begin
            if (!iReq || fin) n.owner = 0;
        end else begin
            if (!dReq) begin
                n.owner = 0; n.words = 0;
            end else if (fin) begin
                n.words = s.words + 1;
                if (n.words >= lim) begin
                    n.owner = 0; n.words = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        m0 <= nextModel(m0, 2, 4, RST, bus0.iREN, bus0.dREN, bus0.dWEN, bus0.ramstate);
        m1 <= nextModel(m1, 1, 4, RST, bus1.iREN, bus1.dREN, bus1.dWEN, bus1.ramstate);
        modelValid <= 1'b1;
    end

    task automatic checkBus(input string p, input mstate_t s,
                            input logic iR, input logic [31:0] ia,
                            input logic dR, input logic dW, input logic [31:0] da,
                            input logic [31:0] ds, input logic [31:0] rl, input logic [1:0] rs,
                            input logic aIwait, input logic [31:0] aIload,
                            input logic aDwait, input logic [31:0] aDload,
                            input logic aRen, input logic aWen, input logic [31:0] aAddr,
                            input logic [31:0] aStore, input logic aMerr);
        logic eRen, eWen, eIwait, eDwait, eMerr;
        logic [31:0] eAddr, eStore;
        eRen = 1'b0; eWen = 1'b0; eAddr = 32'h0; eStore = 32'h0;
        if (s.owner == 1) begin
            eRen = iR; eAddr = ia;
        end else if (s.owner == 2) begin
            eWen = dW; eRen = dR && !dW; eAddr = da; eStore = ds;
        end
        eIwait = !(s.owner == 1 && rs == 2'd2);
        eDwait = !(s.owner == 2 && rs == 2'd2);
        eMerr  = (s.owner != 0) && (rs == 2'd3);
        chk({p, "_ramREN"},   32'(aRen),   32'(eRen));
        chk({p, "_ramWEN"},   32'(aWen),   32'(eWen));
        chk({p, "_ramaddr"},  aAddr,       eAddr);
        chk({p, "_ramstore"}, aStore,      eStore);
        chk({p, "_iwait"},    32'(aIwait), 32'(eIwait));
        chk({p, "_dwait"},    32'(aDwait), 32'(eDwait));
        chk({p, "_merr"},     32'(aMerr),  32'(eMerr));
        chk({p, "_iload"},    aIload,      rl);
        chk({p, "_dload"},    aDload,      rl);
    endtask

    int iDone0 = 0;
    int dDone0 = 0;
    int merr1  = 0;

    // Per-cycle model comparison on the falling edge, plus completion counters.
    always @(negedge CLK) begin
        if (modelValid) begin
            checkBus("b0", m0, bus0.iREN, bus0.iaddr, bus0.dREN, bus0.dWEN, bus0.daddr,
                     bus0.dstore, bus0.ramload, bus0.ramstate, bus0.iwait, bus0.iload,
                     bus0.dwait, bus0.dload, bus0.ramREN, bus0.ramWEN, bus0.ramaddr,
                     bus0.ramstore, bus0.merr);
            checkBus("b1", m1, bus1.iREN, bus1.iaddr, bus1.dREN, bus1.dWEN, bus1.daddr,
                     bus1.dstore, bus1.ramload, bus1.ramstate, bus1.iwait, bus1.iload,
                     bus1.dwait, bus1.dload, bus1.ramREN, bus1.ramWEN, bus1.ramaddr,
                     bus1.ramstore, bus1.merr);
            if (bus0.iwait === 1'b0) iDone0 <= iDone0 + 1;
            if (bus0.dwait === 1'b0) dDone0 <= dDone0 + 1;
            if (bus1.merr === 1'b1) merr1 <= merr1 + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleAll();
        bus0.iREN = 1'b0; bus0.iaddr = 32'h0; bus0.dREN = 1'b0; bus0.dWEN = 1'b0;
        bus0.daddr = 32'h0; bus0.dstore = 32'h0; bus0.ramload = 32'h0; bus0.ramstate = 2'd0;
        bus1.iREN = 1'b0; bus1.iaddr = 32'h0; bus1.dREN = 1'b0; bus1.dWEN = 1'b0;
        bus1.daddr = 32'h0; bus1.dstore = 32'h0; bus1.ramload = 32'h0; bus1.ramstate = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic        recRen[12];
    logic [31:0] recAddr[12];
    logic [31:0] recStarve[12];
    int          expIsI[6];
    int base, g, firstI;

    initial begin
        idleAll();
        RST = 1'b1;
        bus0.iREN = 1'b1; bus0.iaddr = 32'h610; bus0.dREN = 1'b1; bus0.daddr = 32'h600;
        repeat (2) tick();
        // Reset state
        chk("rst_iwait", 32'(bus0.iwait), 32'd1);
        chk("rst_dwait", 32'(bus0.dwait), 32'd1);
        chk("rst_ramREN", 32'(bus0.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus0.ramWEN), 32'd0);
        chk("rst_merr", 32'(bus0.merr), 32'd0);
        chk("rst_starve", 32'(dut0.starveCnt), 32'd0);
        RST = 1'b0;
        // Simultaneous requests at reset release: dcache wins
        tick(); #1;
        chk("rel_ramREN", 32'(bus0.ramREN), 32'd1);
        chk("rel_ramaddr", bus0.ramaddr, 32'h600);
        bus0.ramstate = 2'd2; bus0.ramload = 32'hCAFE0001; #1;
        chk("rel_dwait", 32'(bus0.dwait), 32'd0);
        chk("rel_dload", bus0.dload, 32'hCAFE0001);
        tick(); bus0.iREN = 1'b0; bus0.dREN = 1'b0; bus0.ramstate = 2'd0; #1;
        chk("rel_drop_ramREN", 32'(bus0.ramREN), 32'd0);
        tick();

        // Icache only: ACCESS two cycles after ramREN
        tick(); bus0.iREN = 1'b1; bus0.iaddr = 32'h40; base = iDone0; #1;
        chk("ic_c0_ramREN", 32'(bus0.ramREN), 32'd0);
        tick(); bus0.ramstate = 2'd1; #1;
        chk("ic_c1_ramREN", 32'(bus0.ramREN), 32'd1);
        chk("ic_c1_ramaddr", bus0.ramaddr, 32'h40);
        tick(); #1;
        chk("ic_c2_iwait", 32'(bus0.iwait), 32'd1);
        tick(); bus0.ramstate = 2'd2; bus0.ramload = 32'hDEADBEEF; #1;
        chk("ic_c3_iwait", 32'(bus0.iwait), 32'd0);
        chk("ic_c3_iload", bus0.iload, 32'hDEADBEEF);
        tick(); bus0.iREN = 1'b0; bus0.ramstate = 2'd0; #1;
        chk("ic_c4_ramREN", 32'(bus0.ramREN), 32'd0);
        chk("ic_c4_iwait", 32'(bus0.iwait), 32'd1);
        tick();
        chk("ic_done_count", 32'(iDone0 - base), 32'd1);

        // Dcache two-word write burst without a bubble
        tick(); bus0.dWEN = 1'b1; bus0.daddr = 32'h100; bus0.dstore = 32'h11; base = dDone0; #1;
        chk("db_c0_ramWEN", 32'(bus0.ramWEN), 32'd0);
        tick(); bus0.ramstate = 2'd1; #1;
        chk("db_c1_ramWEN", 32'(bus0.ramWEN), 32'd1);
        chk("db_c1_ramaddr", bus0.ramaddr, 32'h100);
        chk("db_c1_ramstore", bus0.ramstore, 32'h11);
        tick(); bus0.ramstate = 2'd2; #1;
        chk("db_c2_dwait", 32'(bus0.dwait), 32'd0);
        tick(); bus0.daddr = 32'h104; bus0.dstore = 32'h22; bus0.ramstate = 2'd1; #1;
        chk("db_c3_ramWEN", 32'(bus0.ramWEN), 32'd1);
        chk("db_c3_ramaddr", bus0.ramaddr, 32'h104);
        chk("db_c3_ramstore", bus0.ramstore, 32'h22);
        tick(); bus0.ramstate = 2'd2; #1;
        chk("db_c4_dwait", 32'(bus0.dwait), 32'd0);
        tick(); bus0.dWEN = 1'b0; bus0.ramstate = 2'd0; #1;
        chk("db_c5_ramWEN", 32'(bus0.ramWEN), 32'd0);
        chk("db_c5_ramaddr", bus0.ramaddr, 32'h0);
        tick();
        chk("db_done_count", 32'(dDone0 - base), 32'd2);

        // Error on a dcache read (BURST_LEN 1 instance)
        tick(); bus1.dREN = 1'b1; bus1.daddr = 32'h80; base = merr1; #1;
        tick(); bus1.ramstate = 2'd3; #1;
        chk("er_c1_merr", 32'(bus1.merr), 32'd1);
        chk("er_c1_dwait", 32'(bus1.dwait), 32'd1);
        tick(); bus1.ramstate = 2'd0; #1;
        chk("er_c2_ramREN", 32'(bus1.ramREN), 32'd0);
        chk("er_c2_merr", 32'(bus1.merr), 32'd0);
        tick(); bus1.ramstate = 2'd2; #1;
        chk("er_c3_ramREN", 32'(bus1.ramREN), 32'd1);
        chk("er_c3_dwait", 32'(bus1.dwait), 32'd0);
        tick(); bus1.dREN = 1'b0; bus1.ramstate = 2'd0; #1;
        tick();
        chk("er_merr_count", 32'(merr1 - base), 32'd1);

        // Contention, BURST_LEN 1, STARVE_MAX 4: D,D,D,D,I,D
        tick(); bus1.iREN = 1'b1; bus1.iaddr = 32'h200; bus1.dREN = 1'b1;
        bus1.daddr = 32'h300; bus1.ramstate = 2'd2;
        for (int n = 0; n < 12; n++) begin
            tick();
            recRen[n] = bus1.ramREN;
            recAddr[n] = bus1.ramaddr;
            recStarve[n] = 32'(dut1.starveCnt);
        end
        tick(); bus1.iREN = 1'b0; bus1.dREN = 1'b0; bus1.ramstate = 2'd0;
        expIsI[0] = 0; expIsI[1] = 0; expIsI[2] = 0; expIsI[3] = 0; expIsI[4] = 1; expIsI[5] = 0;
        g = 0; firstI = -1;
        for (int n = 0; n < 12; n++) begin
            if (recRen[n]) begin
                if (g < 6) chk($sformatf("ct_grant%0d_isI", g), 32'(recAddr[n] == 32'h200), 32'(expIsI[g]));
                if (recAddr[n] == 32'h200 && firstI < 0) firstI = n;
                g++;
            end
        end
        chk("ct_grant_count", 32'(g), 32'd6);
        chk("ct_firstI_cycle", 32'(firstI), 32'd8);
        if (firstI > 0) begin
            chk("ct_starve_before_I", recStarve[firstI-1], 32'd4);
            chk("ct_starve_at_I", recStarve[firstI], 32'd0);
        end
        tick();

        // Withdrawal in BUSY
        tick(); bus0.iREN = 1'b1; bus0.iaddr = 32'h44; #1;
        tick(); bus0.ramstate = 2'd1; #1;
        chk("wd_c1_ramREN", 32'(bus0.ramREN), 32'd1);
        tick(); bus0.iREN = 1'b0; #1;
        chk("wd_c2_ramREN", 32'(bus0.ramREN), 32'd0);
        chk("wd_c2_iwait", 32'(bus0.iwait), 32'd1);
        tick(); bus0.iREN = 1'b1; bus0.ramstate = 2'd0; #1;
        chk("wd_c3_idle_ramREN", 32'(bus0.ramREN), 32'd0);
        tick(); bus0.ramstate = 2'd2; #1;
        chk("wd_c4_ramREN", 32'(bus0.ramREN), 32'd1);
        chk("wd_c4_iwait", 32'(bus0.iwait), 32'd0);
        tick(); bus0.iREN = 1'b0; bus0.ramstate = 2'd0;

        // Reset asserted mid dcache write
        tick(); bus0.dWEN = 1'b1; bus0.daddr = 32'h500; bus0.dstore = 32'h55; #1;
        tick(); bus0.ramstate = 2'd1; #1;
        chk("rs_c1_ramWEN", 32'(bus0.ramWEN), 32'd1);
        RST = 1'b1;
        tick(); RST = 1'b0; bus0.ramstate = 2'd0; #1;
        chk("rs_ramWEN", 32'(bus0.ramWEN), 32'd0);
        chk("rs_ramaddr", bus0.ramaddr, 32'h0);
        chk("rs_iwait", 32'(bus0.iwait), 32'd1);
        chk("rs_dwait", 32'(bus0.dwait), 32'd1);
        chk("rs_burst0", 32'(dut0.burstCnt), 32'd0);
        chk("rs_starve0", 32'(dut0.starveCnt), 32'd0);
        chk("rs_starve1", 32'(dut1.starveCnt), 32'd0);
        tick(); bus0.dWEN = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
